// File: rtl/subtract_pkg.sv
// rtl/subtract_pkg.sv - shared types and default geometry for the background-subtract frame sequencer
package subtract_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

  localparam int DEF_WIDTH     = 768;
  localparam int DEF_HEIGHT    = 576;
  localparam int DEF_OUT_DEPTH = 32;

  function automatic int frame_pixels(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/subtract_sched_if.sv
// rtl/subtract_sched_if.sv - input FIFO, datapath and output FIFO signals seen by the sequencer
interface subtract_sched_if
  import subtract_pkg::*;
#(
  parameter int XW = $clog2(DEF_WIDTH),
  parameter int YW = $clog2(DEF_HEIGHT)
);
  logic          base_empty;
  logic          img_empty;
  logic          base_rd_en;
  logic          img_rd_en;
  logic          dp_in_valid;
  logic          dp_sof;
  logic          dp_eol;
  logic          dp_eof;
  logic [XW-1:0] dp_x;
  logic [YW-1:0] dp_y;
  logic          dp_out_valid;
  logic [7:0]    dp_out_mask;
  logic          out_empty;
  logic          out_rd_en;

  modport master (
    input  base_empty, img_empty, dp_out_valid, dp_out_mask, out_empty, out_rd_en,
    output base_rd_en, img_rd_en, dp_in_valid, dp_sof, dp_eol, dp_eof, dp_x, dp_y
  );

  modport slave (
    output base_empty, img_empty, dp_out_valid, dp_out_mask, out_empty, out_rd_en,
    input  base_rd_en, img_rd_en, dp_in_valid, dp_sof, dp_eol, dp_eof, dp_x, dp_y
  );
endinterface

// File: rtl/subtract_credit_ctr.sv
// rtl/subtract_credit_ctr.sv - saturating up/down counter; simultaneous inc and dec cancel
module subtract_credit_ctr #(
  parameter int  MAX  = 32,
  parameter int  INIT = 0,
  localparam int CW   = $clog2(MAX + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          underflow
);

  // A decrement against an empty count is reported and the count stays at zero.
  assign underflow = dec && !inc && (count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= CW'(INIT);
    end else if (inc && !dec && (count != CW'(MAX))) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/subtract_sched.sv
// rtl/subtract_sched.sv - credit-gated frame sequencer; SUBTRACT_SCHED_STATS_EN adds fg_count
module subtract_sched
  import subtract_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
`ifdef SUBTRACT_SCHED_STATS_EN
  output logic [$clog2(frame_pixels(WIDTH, HEIGHT) + 1)-1:0] fg_count,
`endif
  subtract_sched_if.master sif
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  sched_state_t  state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] credits;
  logic [CW-1:0] in_flight;
  logic          issue;
  logic          last_x;
  logic          last_y;
  logic          credit_ret;
  logic          credit_uf;
  logic          flight_uf;

  assign last_x     = (x == XW'(WIDTH - 1));
  assign last_y     = (y == YW'(HEIGHT - 1));
  assign credit_ret = sif.out_rd_en && !sif.out_empty;
  // FWFT inputs: the pop strobe doubles as the datapath valid.
  assign issue      = (state == RUN) && !sif.base_empty && !sif.img_empty && (credits != '0);

  assign sif.base_rd_en  = issue;
  assign sif.img_rd_en   = issue;
  assign sif.dp_in_valid = issue;
  assign sif.dp_sof      = issue && (x == '0) && (y == '0);
  assign sif.dp_eol      = issue && last_x;
  assign sif.dp_eof      = issue && last_x && last_y;
  assign sif.dp_x        = x;
  assign sif.dp_y        = y;

  subtract_credit_ctr #(.MAX(OUT_DEPTH), .INIT(OUT_DEPTH)) u_credit (
    .clock     (clock),
    .reset     (reset),
    .inc       (credit_ret),
    .dec       (issue),
    .count     (credits),
    .underflow (credit_uf)
  );

  subtract_credit_ctr #(.MAX(OUT_DEPTH), .INIT(0)) u_flight (
    .clock     (clock),
    .reset     (reset),
    .inc       (issue),
    .dec       (sif.dp_out_valid),
    .count     (in_flight),
    .underflow (flight_uf)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      x     <= '0;
      y     <= '0;
    end else begin
      done <= 1'b0;
      if (flight_uf || credit_uf) err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          x     <= '0;
          y     <= '0;
        end
        RUN: if (issue) begin
          if (last_x) begin
            x <= '0;
            if (last_y) begin
              y     <= '0;
              state <= DRAIN;
            end else begin
              y <= y + 1'b1;
            end
          end else begin
            x <= x + 1'b1;
          end
        end
        DRAIN: if (in_flight == '0) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUBTRACT_SCHED_STATS_EN
  logic [$clog2(frame_pixels(WIDTH, HEIGHT) + 1)-1:0] fg_acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      fg_acc   <= '0;
      fg_count <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        fg_acc <= '0;
      end else if (sif.dp_out_valid && (sif.dp_out_mask != 8'h00)) begin
        fg_acc <= fg_acc + 1'b1;
      end
      if (state == DONE) fg_count <= fg_acc;
    end
  end
`endif

endmodule

// File: tb/tb_subtract_sched.sv
// tb/tb_subtract_sched.sv - directed self-checking bench for subtract_sched on a 4x2 frame with 4 credits
module tb_subtract_sched;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic err;
  logic stray;
`ifdef SUBTRACT_SCHED_STATS_EN
  logic [3:0] fg_count;
`endif

  subtract_sched_if #(.XW(2), .YW(1)) sif ();

  subtract_sched #(.WIDTH(4), .HEIGHT(2), .OUT_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .err   (err),
`ifdef SUBTRACT_SCHED_STATS_EN
    .fg_count (fg_count),
`endif
    .sif   (sif.master)
  );

  always #5 clock = ~clock;

  // Datapath model: fixed latency of 2 cycles, mask chosen by raster position.
  logic [7:0] mask_tab [8] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
  logic [1:0] pv;
  logic [7:0] pm0, pm1;

  always @(posedge clock) begin
    if (reset) begin
      pv <= 2'b00;
    end else begin
      pv  <= {pv[0], sif.dp_in_valid};
      pm0 <= mask_tab[{sif.dp_y, sif.dp_x}];
      pm1 <= pm0;
    end
  end

  assign sif.dp_out_valid = pv[1] | stray;
  assign sif.dp_out_mask  = pm1;

  int cyc = 0, n_iss = 0, n_out = 0, n_done = 0;
  int last_out_cyc = 0, done_cyc = 0, start_cyc = 0;
  bit sof_a [256];
  bit eol_a [256];
  bit eof_a [256];
  int iss_cyc [256];

  always @(posedge clock) begin
    if (sif.dp_in_valid && n_iss < 256) begin
      sof_a[n_iss]   = sif.dp_sof;
      eol_a[n_iss]   = sif.dp_eol;
      eof_a[n_iss]   = sif.dp_eof;
      iss_cyc[n_iss] = cyc;
      n_iss++;
    end
    if (sif.dp_out_valid) begin
      n_out++;
      last_out_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (start && !busy && !reset) start_cyc = cyc;
    cyc++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int snap);
    int k;
    k = 0;
    while (n_done == snap && k < 100) begin
      step();
      k++;
    end
    check(tag, n_done - snap, 1);
  endtask

  function automatic logic [7:0] flag_vec(input int s, input int which);
    logic [7:0] v;
    for (int i = 0; i < 8; i++)
      v[i] = (which == 0) ? sof_a[s + i] : (which == 1) ? eol_a[s + i] : eof_a[s + i];
    return v;
  endfunction

  int s, d, sc, cnt;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stray = 1'b0;
    sif.base_empty = 1'b1;
    sif.img_empty  = 1'b1;
    sif.out_empty  = 1'b1;
    sif.out_rd_en  = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_en", {sif.base_rd_en, sif.img_rd_en}, 0);
    check("rst_dp_flags", {sif.dp_in_valid, sif.dp_sof, sif.dp_eol, sif.dp_eof}, 0);
    check("rst_xy", {sif.dp_x, sif.dp_y}, 0);
    check("rst_credits", dut.credits, 4);

    // Small frame, inputs always ready, output drained every cycle.
    sif.base_empty = 1'b0;
    sif.img_empty  = 1'b0;
    sif.out_empty  = 1'b0;
    sif.out_rd_en  = 1'b1;
    s = n_iss;
    d = n_done;
    pulse_start();
    sc = start_cyc;
    check("busy_after_start", busy, 1);
    step();
    step();
    check("both_valid", sif.dp_in_valid & sif.dp_out_valid, 1);
    check("inflight_pre", dut.in_flight, 2);
    step();
    check("inflight_simul", dut.in_flight, 2);
    check("credits_simul_full", dut.credits, 4);
    wait_done("frame_done", d);
    check("frame_issues", n_iss - s, 8);
    check("first_issue_cyc", iss_cyc[s], sc + 1);
    check("issue_span", iss_cyc[s + 7] - iss_cyc[s], 7);
    check("sof_vec", flag_vec(s, 0), 8'h01);
    check("eol_vec", flag_vec(s, 1), 8'h88);
    check("eof_vec", flag_vec(s, 2), 8'h80);
    check("done_after_out", done_cyc - last_out_cyc, 2);
    check("frame_time", done_cyc - sc, 12);
    check("busy_after_done", busy, 0);
    check("done_pulse_width", done, 0);
`ifdef SUBTRACT_SCHED_STATS_EN
    check("fg_count", fg_count, 4);
`endif

    // Input starvation mid-line.
    s = n_iss;
    d = n_done;
    pulse_start();
    step();
    step();
    sif.img_empty = 1'b1;
    #1;
    check("starve_x_before", sif.dp_x, 2);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cnt += int'(sif.base_rd_en | sif.img_rd_en);
      step();
    end
    check("starve_rd_en", cnt, 0);
    check("starve_x_after", sif.dp_x, 2);
    sif.img_empty = 1'b0;
    wait_done("starve_done", d);
    check("starve_issues", n_iss - s, 8);

    // Backpressure: no credit return.
    sif.out_rd_en = 1'b0;
    s = n_iss;
    d = n_done;
    pulse_start();
    repeat (8) step();
    check("bp_issues", n_iss - s, 4);
    check("bp_credits", dut.credits, 0);
    check("bp_stall", sif.dp_in_valid, 0);
    sif.out_rd_en = 1'b1;
    step();
    sif.out_rd_en = 1'b0;
    #1;
    check("bp_resume", sif.dp_in_valid, 1);
    step();
    check("bp_one_only", sif.dp_in_valid, 0);
    check("bp_issues2", n_iss - s, 5);
    sif.out_rd_en = 1'b1;
    step();
    check("cred_simul_a", dut.credits, 1);
    check("cred_simul_issue", sif.dp_in_valid, 1);
    step();
    check("cred_simul_b", dut.credits, 1);
    wait_done("bp_done", d);
    check("bp_total", n_iss - s, 8);

    // Reset after three pixels, then a clean frame.
    pulse_start();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_credits", dut.credits, 4);
    check("mid_rst_xy", {sif.dp_x, sif.dp_y}, 0);
    check("mid_rst_inflight", dut.in_flight, 0);
    check("mid_rst_err", err, 0);
    s = n_iss;
    d = n_done;
    pulse_start();
    wait_done("post_rst_done", d);
    check("post_rst_issues", n_iss - s, 8);
    check("post_rst_sof", flag_vec(s, 0), 8'h01);

    // Start while busy is ignored.
    s = n_iss;
    d = n_done;
    pulse_start();
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("dbl_done", d);
    repeat (6) step();
    check("dbl_single_done", n_done - d, 1);
    check("dbl_issues", n_iss - s, 8);
    check("dbl_err", err, 0);

    // Stray datapath output with nothing in flight.
    stray = 1'b1;
    step();
    stray = 1'b0;
    check("err_set", err, 1);
    repeat (3) step();
    check("err_sticky", err, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("err_cleared", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/subtract_sched.md
# subtract_sched

Frame sequencer for the background-subtract datapath. On `start`, pops the base and img input FIFOs in lockstep, one pixel pair per cycle, for exactly WIDTH×HEIGHT pixels. Feeds each pair to the subtract datapath with raster position and frame markers. Issues only when output-FIFO space is guaranteed, using a credit counter, so no mask pixel is ever dropped. Sits between the two 24-bit input FIFOs, the subtract datapath and the 8-bit mask output FIFO inside the subtract top level.

## Interface
- WIDTH, 768, pixels per line
- HEIGHT, 576, lines per frame
- OUT_DEPTH, 32, output FIFO depth; initial and maximum credit count
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins one frame
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at frame completion
- err  out  1  sticky; datapath retired with nothing in flight
- base_empty  in  1  base FIFO empty (FWFT)
- img_empty  in  1  img FIFO empty (FWFT)
- base_rd_en  out  1  pop base FIFO
- img_rd_en  out  1  pop img FIFO
- dp_in_valid  out  1  pixel pair valid at the datapath input
- dp_sof  out  1  first pixel of frame (x=0, y=0)
- dp_eol  out  1  last pixel of line
- dp_eof  out  1  last pixel of frame
- dp_x  out  $clog2(WIDTH)  column of the current pixel
- dp_y  out  $clog2(HEIGHT)  row of the current pixel
- dp_out_valid  in  1  datapath produced one mask pixel
- dp_out_mask  in  8  mask value (0x00 or 0xFF)
- out_empty  in  1  output FIFO empty
- out_rd_en  in  1  downstream pop of the output FIFO; returns credit

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `start` moves the block to RUN and clears the x, y and pixel counters. `start` is ignored in every other state.
- RUN: issue = !base_empty && !img_empty && credits != 0. base_rd_en = img_rd_en = dp_in_valid = issue (combinational, FWFT).
- On each issue, x increments. On wrap from x=WIDTH-1, x returns to 0 and y increments.
- dp_sof, dp_eol and dp_eof are decoded from x and y, and are qualified by issue (all 0 when issue=0).
- The issue with dp_eof=1 moves the block to DRAIN.
- DRAIN: no issue. Stay until in_flight == 0, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- credits: reset to OUT_DEPTH. -1 on issue; +1 on (out_rd_en && !out_empty); unchanged when both occur in the same cycle. Saturates at OUT_DEPTH.
- in_flight: +1 on issue, -1 on dp_out_valid, unchanged when both occur. If dp_out_valid arrives with in_flight == 0, set err and hold in_flight at 0.
- Datapath latency is unknown to this block. Credits bound in_flight to at most OUT_DEPTH.
- reset mid-frame: return to IDLE; credits = OUT_DEPTH; in_flight, x, y and err = 0. The FIFOs are not flushed by this block.

## Timing
- Reset values: busy, done, err, rd_ens, dp_in_valid, dp_sof, dp_eol, dp_eof = 0; dp_x, dp_y = 0.
- start accepted at edge N: first issue possible in cycle N+1.
- Steady state: 1 pixel/cycle while both inputs are non-empty and credits != 0.
- If one input FIFO is empty, neither FIFO is popped.
- credits == 0 stalls issue. A credit returned in cycle K permits an issue in cycle K+1.
- done asserts one cycle after the DRAIN exit condition is met. busy falls in the same cycle done rises.
- Minimum frame time is WIDTH×HEIGHT + datapath latency + 2 cycles.

## Configuration
- SUBTRACT_SCHED_STATS_EN defined:
  - Adds output fg_count, width $clog2(WIDTH*HEIGHT+1).
  - An internal counter increments on dp_out_valid && dp_out_mask != 0 and clears when start is accepted.
  - fg_count is loaded from the counter in DONE and holds until the next DONE. Reset value 0.
- Undefined: no fg_count port and no counter logic.

## Structure
- subtract_pkg holds:
  - sched_state_t enum (IDLE, RUN, DRAIN, DONE)
  - default WIDTH, HEIGHT and OUT_DEPTH constants
  - a function returning the frame pixel count
- One sub-module, subtract_credit_ctr, parameterised by MAX. Used twice: for credits (init MAX) and for in_flight (init 0).
- Ports of subtract_credit_ctr: clock, reset, inc, dec, count, underflow.

## Test plan
- Small frame: WIDTH=4, HEIGHT=2, FIFOs always full, out_rd_en every cycle:
  - exactly 8 issues in consecutive cycles
  - dp_sof on issue 0
  - dp_eol on issues 3 and 7
  - dp_eof on issue 7
  - one done pulse after the last dp_out_valid
- Input starvation:
  - img_empty held 1 for 5 cycles mid-line → both rd_ens 0 for those cycles.
  - dp_x is the same before and after the stall.
- Backpressure:
  - OUT_DEPTH=4, out_rd_en=0 → exactly 4 issues, then a stall.
  - One out_rd_en pulse → exactly 1 more issue, starting the next cycle.
- Simultaneous events:
  - issue and credit return in the same cycle → credits unchanged.
  - issue and dp_out_valid in the same cycle → in_flight unchanged.
- Reset and start handling:
  - reset after 3 of 8 pixels → busy=0, credits=OUT_DEPTH, x=y=0.
  - A new start then yields 8 issues with dp_sof on the first.
  - start pulsed while busy → ignored, single done.
- Stats (macro defined): mask pattern 00,FF,FF,00,FF,00,00,FF → fg_count=4 at done.
- Error: stray dp_out_valid in IDLE → err=1, held until reset.
